// File: rtl/skid_fifo_nopass_if.sv
// skid_fifo_nopass_if: valid/ready handshake bundle for both sides of the skid FIFO
interface skid_fifo_nopass_if #(parameter type T = logic [7:0]);
    logic valid_in, ready_in, valid_out, ready_out;
    T     data_in, data_out;
    modport master (output valid_in, data_in, ready_out, input ready_in, valid_out, data_out);
    modport slave  (input valid_in, data_in, ready_out, output ready_in, valid_out, data_out);
endinterface

// File: rtl/skid_fifo_nopass.sv
// skid_fifo_nopass: DEPTH-entry registered-output FIFO with flush and occupancy status
// Optional SKID_FIFO_HWM_EN adds a high-water-mark output of count.
module skid_fifo_nopass #(
    parameter type T            = logic [7:0],
    parameter int  DEPTH        = 4,
    parameter int  AFULL_THRESH = DEPTH - 1,
    parameter T    RESET_DATA   = T'('haa),
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_in,
    skid_fifo_nopass_if.slave bus,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          write_en,
    output logic          read_en
`ifdef SKID_FIFO_HWM_EN
    ,
    output logic [CW-1:0] hwm
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0] count_nxt;

    always_comb begin
        empty         = count == '0;
        full          = count == CW'(DEPTH);
        almost_full   = count >= CW'(AFULL_THRESH);
        bus.valid_out = !empty;
        read_en       = bus.valid_out && bus.ready_out;
        bus.ready_in  = !full || read_en;
        write_en      = bus.valid_in && bus.ready_in;
        bus.data_out  = mem[rd_ptr];
        // explicit wrap so non-power-of-two depths work
        wr_nxt        = wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
        rd_nxt        = rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        count_nxt     = count + CW'(write_en) - CW'(read_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_DATA;
        end else if (flush_in) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_en) begin
                mem[wr_ptr] <= bus.data_in;
                wr_ptr      <= wr_nxt;
            end
            if (read_en) rd_ptr <= rd_nxt;
            count <= count_nxt;
        end
    end

`ifdef SKID_FIFO_HWM_EN
    always_ff @(posedge clk) begin
        if (reset || flush_in) hwm <= '0;
        else if (count_nxt > hwm) hwm <= count_nxt;
    end
`endif

    a_count_max: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
    a_no_ovf:    assert property (@(posedge clk) disable iff (reset) write_en |-> bus.ready_in);
    a_stable:    assert property (@(posedge clk) disable iff (reset)
                     (bus.valid_out && !bus.ready_out && !flush_in) |=> $stable(bus.data_out));
endmodule
